// File: rtl/cpu_common_pkg.sv
// Shared types for the core pipeline: machine word, fetch FSM states and the
// fetch-to-decode payload.
package cpu_common;

   typedef logic [31:0] word_t;

   typedef enum logic {
      FS_RUN    = 1'b0,
      FS_HALTED = 1'b1
   } fetch_state_t;

   // addi x0,x0,0
   localparam word_t NOP_IR = 32'h0000_0013;

   typedef struct packed {
      word_t pc;
      word_t ir;
   } fetch_out_t;

   function automatic word_t align_word(input word_t a);
      return a & ~word_t'(3);
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a fetched instruction that decode could not
// take. Clear has priority over load.
module fetch_skid
   import cpu_common::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_load,
   input  logic       i_clear,
   input  fetch_out_t i_data,
   output logic       o_valid,
   output fetch_out_t o_data
);

   logic       r_valid;
   fetch_out_t r_data;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle-latency instruction BRAM and
// hands {pc, ir} to decode, parking one response in a skid register on stall.
module fetch_stage
   import cpu_common::*;
#(
   parameter word_t RESET_PC = 32'h0000_0000,
   parameter word_t NOP_IR   = cpu_common::NOP_IR
) (
   input  logic  clk_i,
   input  logic  reset_i,
   output word_t imem_addr_o,
   output logic  imem_rd_o,
   input  word_t imem_data_i,
   input  logic  jmp_valid_i,
   input  word_t jmp_addr_i,
   input  logic  halt_i,
   input  logic  ready_i,
   output logic  valid_o,
   output word_t pc_o,
   output word_t ir_o,
   output logic  halted_o
);

   // Decode handshake: {pc_o, ir_o} transfers on a cycle where valid_o && ready_i.
   // valid_o never depends on ready_i; once raised it holds with stable data
   // until taken, unless a redirect, halt or reset squashes it.

   fetch_state_t r_state, w_state_n;
   word_t        r_fetch_pc, w_fetch_pc_n;
   logic         r_inflight_valid, w_inflight_valid_n;
   word_t        r_inflight_pc, w_inflight_pc_n;
   logic         r_boot;

   logic         w_run, w_out_valid, w_jump, w_halt, w_issue, w_accept;
   logic         w_skid_load, w_skid_clear, w_skid_valid;
   word_t        w_issue_addr;
   fetch_out_t   w_skid_data, w_present;

   fetch_skid u_skid (
      .i_clk   (clk_i),
      .i_reset (reset_i),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_data  ({r_inflight_pc, imem_data_i}),
      .o_valid (w_skid_valid),
      .o_data  (w_skid_data)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state          <= FS_RUN;
         r_fetch_pc       <= RESET_PC;
         r_inflight_valid <= 1'b0;
         r_inflight_pc    <= '0;
         r_boot           <= 1'b1;
      end else begin
         r_state          <= w_state_n;
         r_fetch_pc       <= w_fetch_pc_n;
         r_inflight_valid <= w_inflight_valid_n;
         r_inflight_pc    <= w_inflight_pc_n;
         r_boot           <= 1'b0;
      end
   end

   always_comb begin
      // The cycle right after reset is quiet: no issue, no redirect, no halt.
      w_run        = (r_state == FS_RUN) && !r_boot;
      w_out_valid  = w_skid_valid || r_inflight_valid;
      w_jump       = w_run && jmp_valid_i;
      w_halt       = w_run && halt_i && !jmp_valid_i;
      w_issue      = w_jump || (w_run && !halt_i && (ready_i || !w_out_valid));
      w_issue_addr = w_jump ? align_word(jmp_addr_i) : r_fetch_pc;

      w_present = w_skid_valid ? w_skid_data : {r_inflight_pc, imem_data_i};
      valid_o   = w_out_valid && !jmp_valid_i && (r_state == FS_RUN) && !reset_i;
      pc_o      = valid_o ? w_present.pc : '0;
      ir_o      = valid_o ? w_present.ir : NOP_IR;
      w_accept  = valid_o && ready_i;
      halted_o  = (r_state == FS_HALTED) && !reset_i;

      imem_rd_o   = w_issue && !reset_i;
      imem_addr_o = w_issue_addr;

      w_skid_clear = w_jump || w_halt || (w_skid_valid && w_accept);
      w_skid_load  = w_run && !jmp_valid_i && !halt_i && r_inflight_valid && !ready_i;

      w_state_n          = w_halt ? FS_HALTED : r_state;
      w_fetch_pc_n       = w_issue ? w_issue_addr + 32'd4 : r_fetch_pc;
      w_inflight_valid_n = w_issue;
      w_inflight_pc_n    = w_issue ? w_issue_addr : r_inflight_pc;
   end

endmodule
